// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory with combinational read data.
// Port 0 has priority; port 1 is guaranteed a grant after STARVE_MAX consecutive port-0 wins.
module dmem_arbiter #(
  parameter int NUM_WORDS  = 256,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd,
  output logic [1:0]  dbg_state
);

  // Handshake: reqN is held with its we/addr/wdata until gntN pulses; the
  // access then completes with a one-cycle rvalidN (plus errN if out of range)
  // on the following cycle. A reqN still high on that rvalidN cycle is a new request.

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  localparam int             CW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0]  STARVE_LIM = CW'(STARVE_MAX);
  localparam logic [31:0]    LIMIT      = 32'(NUM_WORDS);

  state_t        state, state_nxt;
  logic [CW-1:0] starve_cnt;
  logic          arb, any_req, pick1, take;
  logic          lat_id, lat_we, lat_ok;
  logic [31:0]   lat_addr, lat_wdata;
  logic [31:0]   sel_addr, rd_cap;

  // Every state except ACCESS is an arbitration point, so RESP overlaps the next request.
  assign arb      = (state != ACCESS);
  assign any_req  = req0 | req1;
  assign take     = arb & any_req;
  assign pick1    = req1 & (~req0 | (starve_cnt == STARVE_LIM));
  assign sel_addr = pick1 ? addr1 : addr0;
  assign rd_cap   = (!lat_we && lat_ok) ? mem_rd : 32'd0;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RESP: state_nxt = any_req ? ACCESS : IDLE;
      ACCESS:     state_nxt = RESP;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_id     <= 1'b0;
      lat_we     <= 1'b0;
      lat_ok     <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      starve_cnt <= '0;
      rdata0     <= 32'd0;
      rdata1     <= 32'd0;
    end else begin
      if (take) begin
        lat_id    <= pick1;
        lat_we    <= pick1 ? we1 : we0;
        lat_addr  <= sel_addr;
        lat_wdata <= pick1 ? wdata1 : wdata0;
        lat_ok    <= (sel_addr < LIMIT);
      end
      if (!req1) starve_cnt <= '0;
      else if (take && pick1) starve_cnt <= '0;
      else if (take && starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + CW'(1);
      // Read data is captured as the access closes and held until that port's next completion.
      if (state == ACCESS) begin
        if (lat_id) rdata1 <= rd_cap;
        else        rdata0 <= rd_cap;
      end
    end
  end

  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    rvalid0  = 1'b0;
    rvalid1  = 1'b0;
    err0     = 1'b0;
    err1     = 1'b0;
    mem_we   = 1'b0;
    mem_addr = 32'd0;
    mem_wd   = 32'd0;
    case (state)
      ACCESS: begin
        gnt0     = ~lat_id;
        gnt1     = lat_id;
        mem_addr = lat_addr;
        mem_wd   = lat_wdata;
        mem_we   = lat_we & lat_ok;
      end
      RESP: begin
        rvalid0 = ~lat_id;
        rvalid1 = lat_id;
        err0    = ~lat_id & ~lat_ok;
        err1    = lat_id & ~lat_ok;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter NUM_WORDS, default 256: number of valid word addresses in the attached data memory.
REQ-002 Parameter STARVE_MAX, default 4: maximum number of consecutive grants to port 0 while port 1 is waiting.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 reqN  input  1  port N (N=0,1) access request; held high until gntN.
REQ-006 weN  input  1  port N write enable (1=write, 0=read); valid while reqN is high.
REQ-007 addrN  input  32  port N word address; valid while reqN is high.
REQ-008 wdataN  input  32  port N write data; valid while reqN is high.
REQ-009 gntN  output  1  one-cycle pulse: port N request accepted.
REQ-010 rvalidN  output  1  one-cycle pulse: port N access complete.
REQ-011 rdataN  output  32  port N read data; valid while rvalidN is high.
REQ-012 errN  output  1  pulses with rvalidN when port N's address was >= NUM_WORDS.
REQ-013 mem_addr  output  32  address to the data memory.
REQ-014 mem_wd  output  32  write data to the data memory.
REQ-015 mem_we  output  1  memory write enable.
REQ-016 mem_rd  input  32  memory combinational read data.

Function
REQ-017 FSM states: IDLE, ACCESS, RESP; all outputs are registered, or decoded from registered state only.
REQ-018 Arbitration SHALL occur in IDLE and RESP: if any reqN is high, latch the winner's id, we, addr and wdata, then go to ACCESS. Otherwise go to, or stay in, IDLE.
REQ-019 Priority: port 0 wins whenever req0 is high, unless starve_cnt == STARVE_MAX and req1 is high, in which case port 1 wins.
REQ-020 starve_cnt SHALL be a saturating counter with these updates, applied in order: +1 on a port 0 grant while req1 is high; cleared on any port 1 grant; cleared when req1 is low.
REQ-021 ACCESS SHALL last exactly one cycle.
REQ-022 In ACCESS: gnt(winner)=1; mem_addr = latched addr; mem_wd = latched wdata.
REQ-023 In ACCESS: mem_we = latched we AND (latched addr < NUM_WORDS); the write commits at the closing edge of ACCESS.
REQ-024 At the closing edge of ACCESS, rdata(winner) SHALL capture mem_rd for an in-range read, and 0 for a write or an out-of-range access; the FSM then goes to RESP.
REQ-025 In RESP: rvalid(winner)=1; err(winner)=1 if the latched addr >= NUM_WORDS.
REQ-026 rdataN SHALL hold its value until port N's next completion.
REQ-027 Outside ACCESS: mem_we=0, mem_addr=0, mem_wd=0, gnt0=gnt1=0.
REQ-028 Outside RESP: rvalid0=rvalid1=0 and err0=err1=0.
REQ-029 Latency: a request seen in IDLE gets gnt 1 cycle later and rvalid 2 cycles later.
REQ-030 Back-to-back throughput: one access every 2 cycles (RESP arbitrates the next access).
REQ-031 A requester SHALL deassert reqN, or present a new request, in the cycle after gntN; a still-high reqN in RESP is treated as a new request.
REQ-032 Simultaneous req0 and req1 in IDLE with starve_cnt=0: port 0 is granted; port 1 stays pending.
REQ-033 Address comparison SHALL be an unsigned 32-bit compare; there is no wrap-around or truncation of out-of-range addresses.

Reset
REQ-034 While rst_n=0, these SHALL be forced immediately, independent of clk: state=IDLE, starve_cnt=0, gntN=0, rvalidN=0, errN=0, rdataN=0, mem_we=0, mem_addr=0, mem_wd=0.
REQ-035 Reset asserted during ACCESS SHALL suppress the pending write (mem_we low before the next edge); the access is dropped with no rvalid.
REQ-036 The first arbitration SHALL occur on the first rising edge after rst_n deasserts.

Verification
REQ-037 Port 0 write, addr0=5, wdata0=0xDEADBEEF, then port 0 read of addr 5 -> write: gnt0 at cycle+1, mem_we=1 for one cycle; read: rvalid0 at cycle+2 with rdata0=0xDEADBEEF.
REQ-038 req0 and req1 both held continuously, STARVE_MAX=4 -> grant order 0,0,0,0,1,0,0,0,0,1; each gnt is followed by rvalid to the same port.
REQ-039 Port 1 write to addr 256 -> mem_we stays 0, rvalid1=1 and err1=1 in the same cycle, rdata1=0, memory contents unchanged.
REQ-040 rst_n driven low mid-ACCESS of a write to addr 7 -> mem_we drops without a clock edge, no rvalid, ram[7] unchanged; after reset release, a read of addr 7 returns the prior value.
REQ-041 Single req1 read in IDLE, req0 low -> gnt1 one cycle later, rvalid1 two cycles later; gnt0, rvalid0 and err1 stay 0.
